l1_l2_arbiter: RTL and testbench
================================

# l1_l2_arbiter

Round-robin scheduler that shares the single L2 request/response port between all L1 masters of a workgroup (CPU slots plus the ACP slot). One transaction is in flight at a time: the block accepts a request descriptor from the winning master, forwards it to L2, and routes the L2 response back to that master only. It sits between the per-slot L1 outputs and the L2 cache (or its dummy), replacing ad-hoc fixed-priority selection.

## Interface
Parameters:
- nreq, 5, number of requesters (CFG_CPU_MAX CPU slots + 1 ACP slot), 2..16
- pbits, 128, opaque request descriptor width (address, type, size, data)
- rbits, 256, response payload width (one cache line)
- timeout, 1023, response watchdog limit in cycles, 1..65535 (used only with L1ARB_TIMEOUT_EN)

Ports (one clock; reset is asynchronous and active-low):
- i_clk  in  1  CPU clock
- i_nrst  in  1  asynchronous active-low reset
- i_req_valid  in  nreq  request pending per master
- i_req_payload  in  nreq*pbits  descriptors, master k at [k*pbits +: pbits]
- o_req_ready  out  nreq  accept strobe, one-hot or zero
- o_l2_req_valid  out  1  descriptor valid toward L2
- o_l2_req_payload  out  pbits  latched descriptor
- i_l2_req_ready  in  1  L2 accepts descriptor
- i_l2_resp_valid  in  1  L2 response strobe (no backpressure)
- i_l2_resp_data  in  rbits  response payload
- i_l2_resp_err  in  1  response error
- o_resp_valid  out  nreq  response valid, one-hot to granted master
- o_resp_data  out  rbits  response payload (shared)
- o_resp_err  out  1  response error (shared)
- i_resp_ready  in  nreq  master consumes response
- o_grant_idx  out  4  index of current/last granted master
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT_RESP, RESP.
- IDLE: if any i_req_valid, pick winner = first set bit searching from rr_ptr upward, wrapping at nreq; assert o_req_ready[winner] same cycle (combinational); latch payload, grant index; -> REQ. No valid: stay, o_req_ready=0.
- REQ: o_l2_req_valid=1, payload stable; on i_l2_req_ready -> WAIT_RESP.
- WAIT_RESP: on i_l2_resp_valid latch data/err -> RESP. i_l2_resp_valid in any other state is ignored.
- RESP: o_resp_valid[grant]=1; on i_resp_ready[grant] -> IDLE, rr_ptr = grant+1, wrapping nreq-1 -> 0. i_resp_ready of other masters ignored.
- i_req_valid of losing masters is not acknowledged; they hold valid until granted.
- Reset values: state IDLE, rr_ptr 0, grant 0, all outputs 0, latched payload/data 0.
- Reset mid-transaction discards it; masters re-issue after reset release.

## Timing
- Request accepted cycle 0 (IDLE) -> o_l2_req_valid from cycle 1.
- L2 response at cycle t -> o_resp_valid at t+1.
- Minimum round trip: accept to next accept = 4 cycles with zero-wait L2 and master.
- Fairness: with all masters requesting continuously each gets exactly one grant per nreq transactions.
- Simultaneous i_l2_req_ready and i_l2_resp_valid in REQ: response ignored (L2 must not respond before accept).

## Configuration
- L1ARB_TIMEOUT_EN defined: 16-bit counter cleared on entry to WAIT_RESP, increments each cycle there; when it reaches timeout without a response -> RESP with o_resp_err=1, o_resp_data=0. A response arriving on the same cycle as expiry wins (normal response). Late responses are dropped.
- Not defined: no counter; WAIT_RESP waits indefinitely.

## Structure
- Package l1arb_pkg: state enum (IDLE, REQ, WAIT_RESP, RESP), default timeout constant, descriptor width constants.
- Sub-module l1arb_rr_picker: combinational find-first-from-pointer over nreq bits, outputs valid and index.
- Top holds FSM, latches, optional watchdog.

## Test plan
- Single master 2 requests, L2 ready/response zero-wait -> o_req_ready[2] at cycle 0, o_l2_req_valid cycles 1, o_resp_valid[2] with data 0xA5.. at cycle 3, next accept cycle 4.
- All 5 masters valid continuously, rr_ptr reset 0 -> grant order 0,1,2,3,4,0; no master granted twice before others.
- i_l2_req_ready delayed 7 cycles -> o_l2_req_valid held 7 cycles, payload unchanged.
- Master 3 holds i_resp_ready low 5 cycles -> o_resp_valid[3] held, no new grant, spurious i_resp_ready[1] ignored.
- L1ARB_TIMEOUT_EN, timeout=10, no L2 response -> o_resp_err=1, data 0 after 10 cycles in WAIT_RESP; late response dropped.
- i_nrst asserted in WAIT_RESP -> all outputs 0 immediately, state IDLE, rr_ptr 0.

Source files
------------

// File: rtl/l1_l2_arbiter_pkg.sv
// l1arb_pkg: shared types and constants for the L1->L2 round-robin arbiter.
//   state_t      : arbiter FSM states (IDLE, REQ, WAIT_RESP, RESP)
//   IDX_W        : width of master index / round-robin pointer (up to 16 masters)
//   WD_W         : width of the optional response watchdog counter
//   DEF_*        : default parameter values (requesters, descriptor/response widths, timeout)
//   rr_next()    : advance a round-robin pointer, wrapping at n-1 -> 0
package l1arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    RESP      = 2'd3
  } state_t;

  localparam int IDX_W       = 4;
  localparam int WD_W        = 16;
  localparam int DEF_NREQ    = 5;
  localparam int DEF_PBITS   = 128;
  localparam int DEF_RBITS   = 256;
  localparam int DEF_TIMEOUT = 1023;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] idx, input int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + {{(IDX_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/l1_l2_arbiter_if.sv
// l1_l2_arbiter_if: bundles the L1-side request/response handshakes and the
// L2-side port of the arbiter.
//   slave  modport : arbiter view (inputs i_*, outputs o_*)
//   master modport : environment view (L1 masters + L2 model)
// Signals:
//   i_req_valid/i_req_payload/o_req_ready        : L1 request handshake (per master)
//   o_l2_req_valid/o_l2_req_payload/i_l2_req_ready : request toward L2
//   i_l2_resp_valid/i_l2_resp_data/i_l2_resp_err   : L2 response (no backpressure)
//   o_resp_valid/o_resp_data/o_resp_err/i_resp_ready : response back to L1 masters
//   o_grant_idx/o_busy                             : status
interface l1_l2_arbiter_if
  import l1arb_pkg::*;
#(
  parameter int nreq  = DEF_NREQ,
  parameter int pbits = DEF_PBITS,
  parameter int rbits = DEF_RBITS
);

  logic [nreq-1:0]       i_req_valid;
  logic [nreq*pbits-1:0] i_req_payload;
  logic [nreq-1:0]       o_req_ready;
  logic                  o_l2_req_valid;
  logic [pbits-1:0]      o_l2_req_payload;
  logic                  i_l2_req_ready;
  logic                  i_l2_resp_valid;
  logic [rbits-1:0]      i_l2_resp_data;
  logic                  i_l2_resp_err;
  logic [nreq-1:0]       o_resp_valid;
  logic [rbits-1:0]      o_resp_data;
  logic                  o_resp_err;
  logic [nreq-1:0]       i_resp_ready;
  logic [IDX_W-1:0]      o_grant_idx;
  logic                  o_busy;

  modport slave (
    input  i_req_valid, i_req_payload, i_l2_req_ready, i_l2_resp_valid,
           i_l2_resp_data, i_l2_resp_err, i_resp_ready,
    output o_req_ready, o_l2_req_valid, o_l2_req_payload, o_resp_valid,
           o_resp_data, o_resp_err, o_grant_idx, o_busy
  );

  modport master (
    output i_req_valid, i_req_payload, i_l2_req_ready, i_l2_resp_valid,
           i_l2_resp_data, i_l2_resp_err, i_resp_ready,
    input  o_req_ready, o_l2_req_valid, o_l2_req_payload, o_resp_valid,
           o_resp_data, o_resp_err, o_grant_idx, o_busy
  );

endinterface

// File: rtl/l1_l2_arbiter_rr_picker.sv
// l1arb_rr_picker: combinational round-robin search. Returns the first set
// bit of req found scanning upward from ptr and wrapping at nreq.
//   req   in  nreq   request vector
//   ptr   in  IDX_W  search start position (0..nreq-1)
//   valid out 1      any request set
//   idx   out IDX_W  winning index
module l1arb_rr_picker
  import l1arb_pkg::*;
#(
  parameter int nreq = DEF_NREQ
) (
  input  logic [nreq-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [nreq-1:0]  rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to position ptr; the lowest
    // set bit of rot is then the winner's distance from the pointer.
    rot   = nreq'({req, req} >> ptr);
    valid = |rot;
    off   = '0;
    for (int i = nreq - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(nreq)) sum = sum - (IDX_W+1)'(nreq);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// l1_l2_arbiter: round-robin scheduler sharing one L2 request/response port
// between nreq L1 masters. One transaction in flight at a time:
//   IDLE -> accept winner, latch descriptor -> REQ -> L2 accepts -> WAIT_RESP
//   -> L2 responds (latched) -> RESP -> granted master consumes -> IDLE.
// Ports:
//   i_clk  : clock
//   i_nrst : asynchronous active-low reset
//   bus    : l1_l2_arbiter_if.slave (L1 handshakes, L2 port, status)
// Optional feature: define L1ARB_TIMEOUT_EN to enable the response watchdog.
// After `timeout` cycles in WAIT_RESP without a response the arbiter returns
// an error response (err=1, data=0); a response in the expiry cycle wins.
module l1_l2_arbiter
  import l1arb_pkg::*;
#(
  parameter int nreq    = DEF_NREQ,
  parameter int pbits   = DEF_PBITS,
  parameter int rbits   = DEF_RBITS,
  parameter int timeout = DEF_TIMEOUT
) (
  input logic           i_clk,
  input logic           i_nrst,
  l1_l2_arbiter_if.slave bus
);

  if (nreq < 2 || nreq > 16) begin : g_bad_nreq
    $error("l1_l2_arbiter: nreq out of range 2..16");
  end
  if (timeout < 1 || timeout > 65535) begin : g_bad_timeout
    $error("l1_l2_arbiter: timeout out of range 1..65535");
  end

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic [pbits-1:0] req_pay_q;
  logic [rbits-1:0] resp_data_q;
  logic             resp_err_q;

  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic [nreq-1:0]  pick_onehot;
  logic [nreq-1:0]  grant_onehot;
  logic [pbits-1:0] pick_pay;

  logic             accept;
  logic             resp_take;
  logic             resp_done;
  logic             wd_expire;

  l1arb_rr_picker #(.nreq(nreq)) u_picker (
    .req   (bus.i_req_valid),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pick_onehot  = nreq'(1) << pick_idx;
  assign grant_onehot = nreq'(1) << grant;

  always_comb begin
    pick_pay = '0;
    for (int k = 0; k < nreq; k++) begin
      if (pick_onehot[k]) pick_pay = bus.i_req_payload[k*pbits +: pbits];
    end
  end

`ifdef L1ARB_TIMEOUT_EN
  logic [WD_W-1:0] wd_cnt;

  // Counter sits at 0 on the first WAIT_RESP cycle, so expiry after
  // exactly `timeout` cycles spent waiting.
  assign wd_expire = (wd_cnt == WD_W'(timeout - 1));

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wd_cnt <= '0;
    end else if (state != WAIT_RESP) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    resp_take = 1'b0;
    resp_done = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          accept   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        // A response arriving here is ignored: L2 may not answer before accepting.
        if (bus.i_l2_req_ready) state_nx = WAIT_RESP;
      end
      WAIT_RESP: begin
        if (bus.i_l2_resp_valid) begin
          resp_take = 1'b1;
          state_nx  = RESP;
        end else if (wd_expire) begin
          state_nx  = RESP;
        end
      end
      RESP: begin
        // Only the granted master's ready counts.
        if (|(bus.i_resp_ready & grant_onehot)) begin
          resp_done = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      req_pay_q   <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        grant     <= pick_idx;
        req_pay_q <= pick_pay;
      end
      if (resp_take) begin
        resp_data_q <= bus.i_l2_resp_data;
        resp_err_q  <= bus.i_l2_resp_err;
      end else if (state == WAIT_RESP && wd_expire) begin
        resp_data_q <= '0;
        resp_err_q  <= 1'b1;
      end
      if (resp_done) rr_ptr <= rr_next(grant, nreq);
    end
  end

  // Accept strobe is combinational; hold it low while reset is asserted so
  // every output reads zero during reset.
  assign bus.o_req_ready      = (accept && i_nrst) ? pick_onehot : '0;
  assign bus.o_l2_req_valid   = (state == REQ);
  assign bus.o_l2_req_payload = req_pay_q;
  assign bus.o_resp_valid     = (state == RESP) ? grant_onehot : '0;
  assign bus.o_resp_data      = resp_data_q;
  assign bus.o_resp_err       = resp_err_q;
  assign bus.o_grant_idx      = grant;
  assign bus.o_busy           = (state != IDLE);

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb_l1_l2_arbiter: self-checking bench for l1_l2_arbiter. A transaction-level
// model (pending mask + round-robin pointer, winner chosen by modular
// distance from the pointer) predicts every grant; the bench plays both the
// L1 masters and the L2 cache with random latencies and random data.
// Define L1ARB_TIMEOUT_EN to also exercise the watchdog with timeout=10.
module tb_l1_l2_arbiter;
  localparam int N  = 5;
  localparam int PB = 128;
  localparam int RB = 256;
`ifdef L1ARB_TIMEOUT_EN
  localparam int TMO = 10;
`else
  localparam int TMO = 1023;
`endif

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int errors = 0;

  int            ptr_m = 0;
  logic [N-1:0]  pend  = '0;
  logic [PB-1:0] pay [N];
  bit            keep_all = 1'b0;

  l1_l2_arbiter_if #(.nreq(N), .pbits(PB), .rbits(RB)) bus ();

  l1_l2_arbiter #(.nreq(N), .pbits(PB), .rbits(RB), .timeout(TMO)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RB-1:0] rand256();
    logic [RB-1:0] r;
    for (int i = 0; i < RB / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [PB-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Winner = pending master with the smallest distance (mod N) from the pointer.
  function automatic int model_pick(input logic [N-1:0] p, input int ptr);
    for (int d = 0; d < N; d++) begin
      if (p[(ptr + d) % N]) return (ptr + d) % N;
    end
    return 0;
  endfunction

  task automatic drive_masters();
    bus.i_req_valid = pend;
    for (int k = 0; k < N; k++) bus.i_req_payload[k*PB +: PB] = pay[k];
  endtask

  // One full transaction from IDLE back to IDLE. dreq: L2 accept delay,
  // dresp: L2 response delay, drdy: master consume delay.
  task automatic do_txn(input int dreq, input int dresp, input int drdy,
                        input logic [RB-1:0] rdata, output int w);
    logic [PB-1:0] exp_pay;
    logic          rerr;
    logic [N-1:0]  onehot;
    w      = model_pick(pend, ptr_m);
    onehot = N'(1) << w;
    drive_masters();
    #1;
    chk("accept_ready", 256'(bus.o_req_ready), 256'(onehot));
    chk("accept_busy", 256'(bus.o_busy), 256'(0));
    exp_pay = pay[w];
    step();
    pay[w]  = rand128();
    pend[w] = keep_all ? 1'b1 : 1'($urandom_range(0, 1));
    for (int c = 0; c <= dreq; c++) begin
      bus.i_l2_req_ready  = (c == dreq);
      bus.i_l2_resp_valid = 1'($urandom_range(0, 1));
      bus.i_l2_resp_data  = rand256();
      drive_masters();
      #1;
      chk("req_l2_valid", 256'(bus.o_l2_req_valid), 256'(1));
      chk("req_payload", 256'(bus.o_l2_req_payload), 256'(exp_pay));
      chk("req_no_ready", 256'(bus.o_req_ready), 256'(0));
      step();
    end
    bus.i_l2_req_ready = 1'b0;
    rerr = 1'($urandom_range(0, 1));
    for (int c = 0; c <= dresp; c++) begin
      bus.i_l2_resp_valid = (c == dresp);
      bus.i_l2_resp_data  = (c == dresp) ? rdata : rand256();
      bus.i_l2_resp_err   = (c == dresp) ? rerr : 1'b0;
      #1;
      chk("wait_l2_valid", 256'(bus.o_l2_req_valid), 256'(0));
      chk("wait_resp_valid", 256'(bus.o_resp_valid), 256'(0));
      chk("wait_busy", 256'(bus.o_busy), 256'(1));
      step();
    end
    for (int c = 0; c <= drdy; c++) begin
      bus.i_resp_ready    = (c == drdy) ? onehot : ((N'($urandom) | N'(2)) & ~onehot);
      bus.i_l2_resp_valid = 1'($urandom_range(0, 1));
      bus.i_l2_resp_data  = rand256();
      bus.i_l2_resp_err   = 1'($urandom_range(0, 1));
      #1;
      chk("resp_valid", 256'(bus.o_resp_valid), 256'(onehot));
      chk("resp_data", 256'(bus.o_resp_data), 256'(rdata));
      chk("resp_err", 256'(bus.o_resp_err), 256'(rerr));
      chk("resp_grant", 256'(bus.o_grant_idx), 256'(w));
      chk("resp_no_ready", 256'(bus.o_req_ready), 256'(0));
      step();
    end
    bus.i_resp_ready    = '0;
    bus.i_l2_resp_valid = 1'b0;
    bus.i_l2_resp_err   = 1'b0;
    ptr_m = (w + 1) % N;
  endtask

  initial begin
    int w;
    int exp_order[6] = '{0, 1, 2, 3, 4, 0};

    for (int k = 0; k < N; k++) pay[k] = rand128();
    bus.i_req_valid     = '0;
    bus.i_req_payload   = '0;
    bus.i_l2_req_ready  = 1'b0;
    bus.i_l2_resp_valid = 1'b0;
    bus.i_l2_resp_data  = '0;
    bus.i_l2_resp_err   = 1'b0;
    bus.i_resp_ready    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 256'(bus.o_req_ready), 256'(0));
    chk("rst_l2_valid", 256'(bus.o_l2_req_valid), 256'(0));
    chk("rst_l2_payload", 256'(bus.o_l2_req_payload), 256'(0));
    chk("rst_resp_valid", 256'(bus.o_resp_valid), 256'(0));
    chk("rst_resp_data", 256'(bus.o_resp_data), 256'(0));
    chk("rst_resp_err", 256'(bus.o_resp_err), 256'(0));
    chk("rst_grant", 256'(bus.o_grant_idx), 256'(0));
    chk("rst_busy", 256'(bus.o_busy), 256'(0));
    nrst = 1'b1;

    // All masters requesting continuously: fair rotation from pointer 0
    keep_all = 1'b1;
    pend = '1;
    for (int t = 0; t < 6; t++) begin
      do_txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), rand256(), w);
      chk("fair_order", 256'(w), 256'(exp_order[t]));
    end
    keep_all = 1'b0;

    // Single master 2, zero-wait L2 and master, 4-cycle round trip
    pend = 5'b00100;
    do_txn(0, 0, 0, {32{8'hA5}}, w);
    chk("single_grant", 256'(w), 256'(2));
    pend = 5'b00100;
    do_txn(0, 0, 0, rand256(), w);
    chk("single_back2back", 256'(w), 256'(2));

    // L2 accept delayed 7 cycles
    pend = 5'b10010;
    do_txn(7, 1, 0, rand256(), w);

    // Master 3 delays consumption 5 cycles, spurious ready from master 1
    pend = 5'b01000;
    do_txn(0, 0, 5, rand256(), w);
    chk("hold_grant", 256'(w), 256'(3));

    // Random traffic
    for (int t = 0; t < 16; t++) begin
      pend = pend | N'($urandom);
      if (pend == '0) pend[0] = 1'b1;
      do_txn($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 3), rand256(), w);
    end

    // Reset during WAIT_RESP: outputs clear immediately, pointer returns to 0
    pend = 5'b00100;
    do_txn(0, 0, 0, rand256(), w);
    pend = 5'b00100;
    drive_masters();
    step();
    bus.i_l2_req_ready = 1'b1;
    step();
    bus.i_l2_req_ready = 1'b0;
    chk("pre_rst_busy", 256'(bus.o_busy), 256'(1));
    nrst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 256'(bus.o_req_ready), 256'(0));
    chk("mid_rst_l2_valid", 256'(bus.o_l2_req_valid), 256'(0));
    chk("mid_rst_l2_payload", 256'(bus.o_l2_req_payload), 256'(0));
    chk("mid_rst_resp_valid", 256'(bus.o_resp_valid), 256'(0));
    chk("mid_rst_resp_data", 256'(bus.o_resp_data), 256'(0));
    chk("mid_rst_grant", 256'(bus.o_grant_idx), 256'(0));
    chk("mid_rst_busy", 256'(bus.o_busy), 256'(0));
    step();
    step();
    nrst = 1'b1;
    ptr_m = 0;
    pend = 5'b10001;
    do_txn(0, 0, 0, rand256(), w);
    chk("post_rst_ptr0", 256'(w), 256'(0));

`ifdef L1ARB_TIMEOUT_EN
    // Watchdog: no L2 response -> error response after TMO cycles
    pend = 5'b00010;
    drive_masters();
    #1;
    chk("tmo_accept", 256'(bus.o_req_ready), 256'(5'b00010));
    step();
    pend = '0;
    drive_masters();
    bus.i_l2_req_ready = 1'b1;
    step();
    bus.i_l2_req_ready = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      #1;
      chk("tmo_wait", 256'(bus.o_resp_valid), 256'(0));
      step();
    end
    bus.i_l2_resp_valid = 1'b1;
    bus.i_l2_resp_data  = '1;
    #1;
    chk("tmo_resp_valid", 256'(bus.o_resp_valid), 256'(5'b00010));
    chk("tmo_resp_err", 256'(bus.o_resp_err), 256'(1));
    chk("tmo_resp_data", 256'(bus.o_resp_data), 256'(0));
    step();
    bus.i_resp_ready = 5'b00010;
    #1;
    chk("tmo_late_dropped", 256'(bus.o_resp_data), 256'(0));
    step();
    bus.i_resp_ready = '0;
    #1;
    chk("tmo_idle", 256'(bus.o_busy), 256'(0));
    step();
    bus.i_l2_resp_valid = 1'b0;
    #1;
    chk("tmo_idle_resp_ignored", 256'(bus.o_resp_valid), 256'(0));
    chk("tmo_idle_data", 256'(bus.o_resp_data), 256'(0));
    ptr_m = 2;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
